controlador_varredura_matriz: RTL

CONTROLADOR_VARREDURA_MATRIZ -- requirements
Module: controlador_varredura_matriz

---
 rtl/matriz_pkg.sv | 46 ++++
 rtl/divisor_varredura.sv | 42 ++++
 rtl/controlador_varredura_matriz.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/matriz_pkg.sv
// ============================================================================
// Module      : matriz_pkg
// Description : Shared definitions for the column-scan matrix controller:
//               controller state encoding, column-register load value,
//               glyph ROM (4 glyphs x 7 columns x 5 rows) and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matriz_pkg;

    // Controller states: load (CARGA) holds the scan at column 0,
    // scan (VARRE) walks the columns on every divider tick.
    typedef enum logic [0:0] {
        CARGA = 1'b0,
        VARRE = 1'b1
    } estado_t;

    // Value loaded into the external column ring register
    localparam logic [6:0] c_valor_carga = 7'b0000001;

    localparam int c_num_colunas = 7;

    // Glyph ROM, indexed [glyph][column]; bit 0 is the top row.
    // Glyph 0 is blank, glyph 1 lights every LED, glyph 2 is an 'A'
    // and glyph 3 is a checkerboard.
    localparam logic [0:3][0:6][4:0] c_glifo_rom = '{
        '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000},
        '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111},
        '{5'b11110, 5'b00101, 5'b00101, 5'b00101, 5'b11110, 5'b00000, 5'b00000},
        '{5'b10101, 5'b01010, 5'b10101, 5'b01010, 5'b10101, 5'b01010, 5'b10101}
    };

    // Width of a counter that must hold 0..div-1
    function automatic int largura_contador(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // One-hot column pattern expected from the ring register at a given index
    function automatic logic [6:0] um_quente(input logic [2:0] idx);
        return c_valor_carga << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_varredura.sv
// ============================================================================
// Module      : divisor_varredura
// Description : Free-running column-period divider. Counts 0..DIV-1 and
//               flags the last count of each period with a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_varredura
    import matriz_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    output logic                              tick,
    output logic [largura_contador(DIV)-1:0]  count
);

    localparam int                c_cw     = largura_contador(DIV);
    localparam logic [c_cw-1:0]   c_ultimo = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_count;

    // Period counter, wraps to 0 after DIV-1 regardless of controller mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_count == c_ultimo) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Tick is decoded from the register, so it is low while reset holds count at 0
    assign tick  = (r_count == c_ultimo);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/controlador_varredura_matriz.sv
// ============================================================================
// Module      : controlador_varredura_matriz
// Description : 7x5 LED matrix column-scan controller. Steps a column index
//               on each divider tick, drives the glyph rows for the active
//               column, and checks the external one-hot column register
//               against the index (sticky error flag).
//               Optional build macro CONTROLADOR_BLANKING_EN: rows are held
//               dark for BLANK_CYC cycles after every column change.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_varredura_matriz
    import matriz_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ch1,
    input  logic        ch0,
    input  logic [1:0]  simbolo,
    input  logic [6:0]  coluna_in,
    output logic [6:0]  valores_coluna,
    output logic        tick_desloca,
    output logic [4:0]  linhas,
    output logic [2:0]  indice_coluna,
    output logic        erro_sinc
);

    localparam int c_cw = largura_contador(DIV);

    estado_t          r_estado;
    estado_t          w_estado_prox;
    logic             w_tick;
    logic [c_cw-1:0]  w_count;
    logic             w_carga_req;
    logic             w_avanca;
    logic [2:0]       w_indice_prox;
    logic [2:0]       r_indice;
    logic [4:0]       r_linhas;
    logic             r_cmp_pend;
    logic             r_erro;

    divisor_varredura #(
        .DIV (DIV)
    ) u_divisor (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick),
        .count   (w_count)
    );

    // Load mode is requested by the keys directly so it can pre-empt a tick
    assign w_carga_req = ({ch1, ch0} == 2'b00);

    // Controller state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= CARGA;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Next state, column-advance decision and next column index
    always_comb begin
        w_estado_prox = VARRE;
        w_avanca      = 1'b0;
        w_indice_prox = r_indice + 3'd1;
        if (w_carga_req) begin
            w_estado_prox = CARGA;
        end
        // A load request on a tick cycle wins: no advance, no compare later
        if ((r_estado == VARRE) && w_tick && !w_carga_req) begin
            w_avanca = 1'b1;
        end
        if (r_indice == 3'(c_num_colunas - 1)) begin
            w_indice_prox = 3'd0;
        end
    end

    // Column index, row register and compare-pending flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_indice   <= 3'd0;
            r_linhas   <= 5'd0;
            r_cmp_pend <= 1'b0;
        end else if (w_carga_req) begin
            r_indice   <= 3'd0;
            r_linhas   <= 5'd0;
            r_cmp_pend <= 1'b0;
        end else begin
            // The ring register shifts on the same edge, so it is checked one cycle later
            r_cmp_pend <= w_avanca;
            if (w_avanca) begin
                r_indice <= w_indice_prox;
                r_linhas <= c_glifo_rom[simbolo][w_indice_prox];
            end
        end
    end

    // Sticky synchronisation error: set on a column mismatch, cleared only in load mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_erro <= 1'b0;
        end else if (r_estado == CARGA) begin
            r_erro <= 1'b0;
        end else if (r_cmp_pend && !w_carga_req && (coluna_in != um_quente(r_indice))) begin
            r_erro <= 1'b1;
        end
    end

    assign valores_coluna = c_valor_carga;
    assign tick_desloca   = w_tick;
    assign indice_coluna  = r_indice;
    assign erro_sinc      = r_erro;

`ifdef CONTROLADOR_BLANKING_EN
    // The divider restarts at 0 right after each tick, so its low counts
    // mark the dark interval that follows a column change.
    always_comb begin
        linhas = r_linhas;
        if (w_count < c_cw'(BLANK_CYC)) begin
            linhas = 5'd0;
        end
    end
`else
    // Rows come straight from the row register; divider phase is not needed
    assign linhas = r_linhas;

    localparam int c_unused_blank_cyc = BLANK_CYC;
    logic w_unused_count;
    assign w_unused_count = ^w_count;
`endif

endmodule

`default_nettype wire
